// File: rtl/obi_data_mem_responder_if.sv
// Data-side OBI bus between the LSU (master) and the behavioural data memory (slave).
interface obi_data_mem_responder_if;
    logic        data_req_i;
    logic        data_gnt_o;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic [5:0]  data_atop_i;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;

    modport master (
        output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i, data_atop_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );

    modport slave (
        input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i, data_atop_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );
endinterface

// File: rtl/obi_data_mem_responder.sv
// Behavioural data memory answering LSU OBI transactions with in-order, latency-controlled
// responses, grant/response stall injection and error responses.
module obi_data_mem_responder #(
    parameter int          MEM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          OUTSTANDING = 2,
    parameter int          RSP_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    obi_data_mem_responder_if.slave       bus,
    input  logic                          gnt_stall_i,
    input  logic                          rsp_stall_i
);
    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING + 1);

    logic [31:0]      mem [MEM_WORDS];

    logic [31:0]      q_rdata [OUTSTANDING];
    logic             q_err   [OUTSTANDING];
    logic [2:0]       q_age   [OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [31:0]      word_off;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic             acc_err;
    logic             accept;
    logic             pop;
    logic [31:0]      push_rdata;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign word_off = (bus.data_addr_i - BASE_ADDR) >> 2;
    assign in_range = (bus.data_addr_i >= BASE_ADDR) && (word_off < 32'(MEM_WORDS));
    assign idx      = word_off[IDX_W-1:0];
    assign acc_err  = !in_range || (bus.data_atop_i != '0);

    // Grant looks only at the current occupancy: a pop on this edge does not free a slot early.
    assign bus.data_gnt_o = rst_n & bus.data_req_i & ~gnt_stall_i & (count < CNT_W'(OUTSTANDING));
    assign accept         = bus.data_gnt_o;

    // Reads snapshot the word before any same-edge write lands.
    assign push_rdata = (acc_err || bus.data_we_i) ? 32'h0 : mem[idx];

    assign pop = (count != '0) && (q_age[rd_ptr] >= 3'(RSP_LATENCY - 1)) && !rsp_stall_i;

    always_ff @(posedge clk) begin
        if (accept && bus.data_we_i && !acc_err) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.data_be_i[k]) mem[idx][8*k +: 8] <= bus.data_wdata_i[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < OUTSTANDING; i++) begin
                q_rdata[i] <= '0;
                q_err[i]   <= 1'b0;
                q_age[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < OUTSTANDING; i++) begin
                if (q_age[i] < 3'(RSP_LATENCY)) q_age[i] <= q_age[i] + 3'd1;
            end
            if (accept) begin
                q_rdata[wr_ptr] <= push_rdata;
                q_err[wr_ptr]   <= acc_err;
                q_age[wr_ptr]   <= '0;
                wr_ptr          <= ptr_next(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_next(rd_ptr);
            if (accept && !pop)      count <= count + 1'b1;
            else if (!accept && pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.data_rvalid_o <= 1'b0;
            bus.data_rdata_o  <= '0;
            bus.data_err_o    <= 1'b0;
        end else if (pop) begin
            bus.data_rvalid_o <= 1'b1;
            bus.data_rdata_o  <= q_rdata[rd_ptr];
            bus.data_err_o    <= q_err[rd_ptr];
        end else begin
            bus.data_rvalid_o <= 1'b0;
            bus.data_rdata_o  <= '0;
            bus.data_err_o    <= 1'b0;
        end
    end

    a_addr_phase_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.data_req_i && !bus.data_gnt_o) |=>
            ($stable(bus.data_addr_i) && $stable(bus.data_we_i) &&
             $stable(bus.data_be_i) && $stable(bus.data_wdata_i)));
endmodule
